// File: rtl/keccak_pkg.sv
// Shared Keccak parameters, domain-separation bytes and the padder state type.
package keccak_pkg;

  localparam int w          = 64;
  localparam int rate       = 1088;
  localparam int RATE_WORDS = rate / w;

  localparam logic [7:0] DS_SHA3  = 8'h06;
  localparam logic [7:0] DS_SHAKE = 8'h1F;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_MSG,
    PAD_PAD,
    PAD_ZERO
  } pad_state_t;

endpackage

// File: rtl/keccak_padder_if.sv
// Message-in / padded-words-out bus of the Keccak absorb front end.
//
// Handshake rule for both streams: a word moves on a rising clock edge where
// valid & ready are both high. The producer holds data and flags stable while
// valid is high and ready is low, and valid never depends on ready.
// start/size_in are a plain one-cycle command pulse with no ready.
interface keccak_padder_if
  import keccak_pkg::*;
#(
  parameter int W = w
) ();

  logic             start;
  logic [15:0]      size_in;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     data_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     data_out;
  logic             block_last;
  logic             msg_last;
  logic             busy;
  pad_state_t       state;

  modport master (
    output start, size_in, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, block_last, msg_last, busy, state
  );

  modport slave (
    input  start, size_in, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, block_last, msg_last, busy, state
  );

endinterface

// File: rtl/keccak_pad_word.sv
// Combinational word former: keeps the first k bytes, optionally places the
// domain-separation byte at byte k and ORs the final 0x80 into the top byte.
// A plain data word is k=W/8, a pad word k=0 with insert_ds, a zero word k=0.
module keccak_pad_word #(
  parameter  int         W       = 64,
  parameter  logic [7:0] DS_BYTE = 8'h06,
  localparam int         NB      = W / 8,
  localparam int         KW      = $clog2(NB + 1)
) (
  input  logic [W-1:0]  word,
  input  logic [KW-1:0] k,
  input  logic          insert_ds,
  input  logic          insert_final,
  output logic [W-1:0]  padded
);

  // Byte-wise mask / DS insertion, then the pad10*1 terminator on top.
  always_comb begin
    padded = '0;
    for (int i = 0; i < NB; i++) begin
      if (KW'(i) < k) begin
        padded[8*i +: 8] = word[8*i +: 8];
      end else if (insert_ds && (KW'(i) == k)) begin
        padded[8*i +: 8] = DS_BYTE;
      end
    end
    if (insert_final) begin
      padded[W-1 -: 8] = padded[W-1 -: 8] | 8'h80;
    end
  end

endmodule

// File: rtl/keccak_padder.sv
// Keccak absorb-side padder: masks the tail of a byte-length-tagged message,
// appends DS_BYTE and pad10*1, and emits whole RATE-bit blocks word by word
// through a single output register stage.
module keccak_padder
  import keccak_pkg::*;
#(
  parameter int         W       = w,
  parameter int         RATE    = rate,
  parameter logic [7:0] DS_BYTE = DS_SHA3
) (
  input  logic            clk,
  input  logic            rst,
  keccak_padder_if.slave  bus
);

  localparam int              NB       = W / 8;
  localparam int              KW       = $clog2(NB + 1);
  localparam int              RW       = RATE / W;
  localparam int              IW       = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [15:0]     NB16     = 16'(NB);
  localparam logic [IW-1:0]   LAST_IDX = IW'(RW - 1);

  pad_state_t    state_q, state_d;
  logic [15:0]   bytes_left_q, bytes_left_d;
  // Index within the block of the next word to enter the output register.
  // Every loaded word is transferred exactly once, so this tracks the
  // transfer count of the emitted stream.
  logic [IW-1:0] word_idx_q;
  logic          busy_q;
  logic          out_valid_q;
  logic [W-1:0]  data_out_q;
  logic          block_last_q;
  logic          msg_last_q;

  logic          load;
  logic          in_ready;
  logic          in_fire;
  logic          start_fire;
  logic          is_bl;
  logic          emit;
  logic [W-1:0]  pw_word;
  logic [KW-1:0] pw_k;
  logic          pw_ds;
  logic          pw_final;
  logic [W-1:0]  pw_out;

  assign load       = !out_valid_q || bus.out_ready;
  assign in_ready   = (state_q == PAD_MSG) && load;
  assign in_fire    = bus.in_valid && in_ready;
  assign start_fire = bus.start && (state_q == PAD_IDLE) && !busy_q;
  assign is_bl      = (word_idx_q == LAST_IDX);

  keccak_pad_word #(
    .W       (W),
    .DS_BYTE (DS_BYTE)
  ) u_pad_word (
    .word         (pw_word),
    .k            (pw_k),
    .insert_ds    (pw_ds),
    .insert_final (pw_final),
    .padded       (pw_out)
  );

  // Next state, byte countdown and the shape of the word to emit this cycle.
  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    emit         = 1'b0;
    pw_word      = '0;
    pw_k         = '0;
    pw_ds        = 1'b0;
    pw_final     = 1'b0;
    case (state_q)
      PAD_IDLE: begin
        if (start_fire) begin
          bytes_left_d = bus.size_in;
          state_d      = (bus.size_in == 16'd0) ? PAD_PAD : PAD_MSG;
        end
      end
      PAD_MSG: begin
        if (in_fire) begin
          emit    = 1'b1;
          pw_word = bus.data_in;
          if (bytes_left_q > NB16) begin
            pw_k         = KW'(NB);
            bytes_left_d = bytes_left_q - NB16;
          end else if (bytes_left_q == NB16) begin
            // Message ends on a word boundary: padding goes in its own word.
            pw_k         = KW'(NB);
            bytes_left_d = '0;
            state_d      = PAD_PAD;
          end else begin
            pw_k         = bytes_left_q[KW-1:0];
            pw_ds        = 1'b1;
            pw_final     = is_bl;
            bytes_left_d = '0;
            state_d      = is_bl ? PAD_IDLE : PAD_ZERO;
          end
        end
      end
      PAD_PAD: begin
        if (load) begin
          emit     = 1'b1;
          pw_ds    = 1'b1;
          pw_final = is_bl;
          state_d  = is_bl ? PAD_IDLE : PAD_ZERO;
        end
      end
      PAD_ZERO: begin
        if (load) begin
          emit     = 1'b1;
          pw_final = is_bl;
          if (is_bl) state_d = PAD_IDLE;
        end
      end
      default: state_d = PAD_IDLE;
    endcase
  end

  // FSM state and remaining message bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PAD_IDLE;
      bytes_left_q <= '0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
    end
  end

  // Word position inside the current block, wrapping at the block end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_q <= '0;
    end else if (emit) begin
      word_idx_q <= is_bl ? '0 : word_idx_q + 1'b1;
    end
  end

  // busy spans from the accepted start to the accepted msg_last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else if (start_fire) begin
      busy_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready && msg_last_q) begin
      busy_q <= 1'b0;
    end
  end

  // Output register: reloads only when empty or being drained, so a stalled
  // word and its flags stay put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      block_last_q <= 1'b0;
      msg_last_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= emit;
      if (emit) begin
        data_out_q   <= pw_out;
        block_last_q <= is_bl;
        msg_last_q   <= pw_final;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.block_last = block_last_q;
  assign bus.msg_last   = msg_last_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder (W=64, RATE=1088, DS=0x06, 17 words/block).
module tb_keccak_padder;
  import keccak_pkg::*;

  localparam int         TW  = 64;
  localparam int         RB  = 136;
  localparam int         TRW = 17;
  localparam logic [7:0] DS  = 8'h06;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keccak_padder_if #(.W(TW)) bus ();

  keccak_padder #(.W(TW), .RATE(1088), .DS_BYTE(DS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock: posedges at 5,15,...; inputs change on negedge, sampled 4 later.
  always #5 clk = ~clk;

  logic [TW-1:0] exp_q[$];
  bit            exp_bl[$];
  bit            exp_ml[$];
  logic [TW-1:0] got_q[$];
  bit            got_bl[$];
  bit            got_ml[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            in_fires    = 0;
  bit            all_ones    = 1'b0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [TW-1:0] src_word(input int j);
    if (all_ones) return '1;
    return 64'h0123_4567_89AB_CDEF ^ (64'(j) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  // Reference: byte-oriented padded message, then split into LE words.
  task automatic build_exp(input int size);
    int nblk;
    int len;
    logic [TW-1:0] sw;
    logic [TW-1:0] wd;
    logic [7:0] b;
    int p;
    exp_q.delete(); exp_bl.delete(); exp_ml.delete();
    nblk = size / RB + 1;
    len  = nblk * RB;
    for (int wi = 0; wi < len / 8; wi++) begin
      wd = '0;
      for (int bi = 0; bi < 8; bi++) begin
        p = wi * 8 + bi;
        sw = src_word(p / 8);
        if (p < size)       b = sw[8*(p%8) +: 8];
        else if (p == size) b = DS;
        else                b = 8'h00;
        if (p == len - 1)   b = b | 8'h80;
        wd[8*bi +: 8] = b;
      end
      exp_q.push_back(wd);
      exp_bl.push_back((wi % TRW) == TRW - 1);
      exp_ml.push_back(wi == len / 8 - 1);
    end
  endtask

  // Driver: feeds the message words with random in_valid gaps.
  task automatic feed(input int size, input int gap);
    int nw;
    int j;
    int cyc;
    nw = (size + 7) / 8;
    j = 0;
    cyc = 0;
    while (j < nw && cyc < 4000) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(99) >= gap);
      bus.data_in  = src_word(j);
      #4;
      cyc++;
      if (bus.in_valid && bus.in_ready) j++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Collector: random out_ready, stall-hold checks, records accepted words.
  task automatic collect(input int stall, input bit poke);
    int cyc;
    bit done;
    bit prev_stall;
    logic [TW-1:0] prev_data;
    bit prev_bl;
    bit prev_ml;
    cyc = 0;
    done = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_bl = 1'b0;
    prev_ml = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(99) >= stall);
      bus.start     = poke && (cyc == 3);
      bus.size_in   = poke ? 16'd5 : bus.size_in;
      #4;
      cyc++;
      if (bus.in_valid && bus.in_ready) in_fires++;
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.data_out, prev_data);
        check("hold_block_last", bus.block_last, prev_bl);
        check("hold_msg_last", bus.msg_last, prev_ml);
      end
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.data_out);
        got_bl.push_back(bus.block_last);
        got_ml.push_back(bus.msg_last);
        if (bus.msg_last) done = 1'b1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.data_out;
      prev_bl    = bus.block_last;
      prev_ml    = bus.msg_last;
    end
    check("msg_done_in_budget", done, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic run_msg(input int size, input int gap, input int stall, input bit poke);
    int n;
    build_exp(size);
    got_q.delete(); got_bl.delete(); got_ml.delete();
    in_fires = 0;
    @(negedge clk);
    bus.size_in = 16'(size);
    bus.start   = 1'b1;
    if (size == 0) begin
      bus.in_valid = 1'b1;
      bus.data_in  = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    @(negedge clk);
    bus.start = 1'b0;
    #4;
    check($sformatf("busy_after_start_s%0d", size), bus.busy, 1'b1);
    fork
      feed(size, gap);
      collect(stall, poke);
    join
    bus.in_valid = 1'b0;
    #4;
    check($sformatf("busy_clear_s%0d", size), bus.busy, 1'b0);
    check($sformatf("state_idle_s%0d", size), bus.state, PAD_IDLE);
    check($sformatf("in_words_s%0d", size), in_fires, (size + 7) / 8);
    check($sformatf("word_count_s%0d", size), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("s%0d_w%0d_data", size, i), got_q[i], exp_q[i]);
      check($sformatf("s%0d_w%0d_block_last", size, i), got_bl[i], exp_bl[i]);
      check($sformatf("s%0d_w%0d_msg_last", size, i), got_ml[i], exp_ml[i]);
    end
  endtask

  function automatic logic [TW-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  initial begin
    logic [TW-1:0] wv;
    logic [TW-1:0] sw;
    bus.start     = 1'b0;
    bus.size_in   = '0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data_out", bus.data_out, '0);
    check("rst_block_last", bus.block_last, 1'b0);
    check("rst_msg_last", bus.msg_last, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_state", bus.state, PAD_IDLE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Empty message: one pad block, no input consumed
    run_msg(0, 0, 0, 1'b0);
    check("s0_w0", got_at(0), 64'h0000_0000_0000_0006);
    check("s0_w8", got_at(8), 64'h0);
    check("s0_w16", got_at(16), 64'h8000_0000_0000_0000);
    check("s0_in_fires", in_fires, 0);

    // Three bytes of all-ones: tail masked, DS at byte 3
    all_ones = 1'b1;
    run_msg(3, 0, 0, 1'b0);
    check("s3_w0", got_at(0), 64'h0000_0000_06FF_FFFF);
    check("s3_w16", got_at(16), 64'h8000_0000_0000_0000);
    all_ones = 1'b0;

    // One full word: DS goes in the next word
    run_msg(8, 0, 0, 1'b0);
    sw = src_word(0);
    check("s8_w0", got_at(0), sw);
    check("s8_w1", got_at(1), 64'h0000_0000_0000_0006);
    check("s8_w16", got_at(16), 64'h8000_0000_0000_0000);

    // One byte short of a block: DS and 0x80 share the top byte
    run_msg(135, 0, 0, 1'b0);
    wv = got_at(16);
    sw = src_word(16);
    check("s135_top_byte", wv[63:56], 8'h86);
    check("s135_low_bytes", wv[55:0], sw[55:0]);

    // Exactly one block: extra full pad block follows
    run_msg(136, 0, 0, 1'b0);
    check("s136_count", got_q.size(), 34);
    check("s136_w16_ml", got_ml.size() > 16 ? got_ml[16] : 1'bx, 1'b0);
    check("s136_w16_bl", got_bl.size() > 16 ? got_bl[16] : 1'bx, 1'b1);
    check("s136_w17", got_at(17), 64'h0000_0000_0000_0006);
    check("s136_w33", got_at(33), 64'h8000_0000_0000_0000);

    // Random backpressure and input gaps, with a start poked mid-message
    run_msg(137, 30, 40, 1'b1);
    run_msg(271, 50, 20, 1'b0);
    run_msg(272, 20, 50, 1'b1);
    all_ones = 1'b1;
    run_msg(60, 40, 40, 1'b0);
    all_ones = 1'b0;
    run_msg($urandom_range(1, 400), 25, 25, 1'b0);

    // Async reset mid-block, then a clean message
    @(negedge clk);
    bus.size_in = 16'd500;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = src_word(i);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_data_out", bus.data_out, '0);
    check("mid_rst_block_last", bus.block_last, 1'b0);
    check("mid_rst_msg_last", bus.msg_last, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_state", bus.state, PAD_IDLE);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_msg(40, 20, 20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
